d_sram_axi_bridge: RTL and testbench
====================================

# d_sram_axi_bridge

Converts the data cache's SRAM-like miss/write-back port into single-beat AXI3 master transactions. It sits directly downstream of the data cache and upstream of the AXI crossbar/memory. It accepts one request at a time, issues the matching AR or AW+W transaction, and returns read data or write completion as a one-cycle `data_ok`.

## Interface
Parameters:
- `ID_W`, 4: AXI ID width.
- `AXI_ID`, 1: constant ID driven on `arid`/`awid`/`wid`; the data side is ID 1.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `data_req`  in  1  request from d-cache.
- `data_wr`  in  1  1 = write, 0 = read.
- `data_size`  in  2  0 = byte, 1 = half, 2 = word.
- `data_addr`  in  32  byte address.
- `data_wdata`  in  32  write data.
- `data_rdata`  out  32  read data, valid when `data_ok` is high on a read.
- `data_addr_ok`  out  1  request accepted this cycle.
- `data_data_ok`  out  1  one-cycle completion pulse.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`  out  ID_W/32/4/3/2  AR channel. `arlen`=0, `arburst`=2'b01.
- `arlock`/`arcache`/`arprot`  out  2/4/3  tied 0.
- `arvalid` out 1, `arready` in 1.
- `rid` in ID_W, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`  out  as AR.
- `awlock`/`awcache`/`awprot`  out  2/4/3  tied 0.
- `awvalid` out 1, `awready` in 1.
- `wid` out ID_W, `wdata` out 32, `wstrb` out 4, `wlast` out 1 (always 1), `wvalid` out 1, `wready` in 1.
- `bid` in ID_W, `bresp` in 2, `bvalid` in 1, `bready` out 1.

## Operation
- FSM states: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE:
  - `data_addr_ok` = `data_req`.
  - On `data_req`, latch wr, size, addr and wdata.
  - Go to RADDR if read, WREQ if write.
- RADDR: `arvalid`=1 from the latched fields. On `arready`, go to RDATA.
- RDATA: `rready`=1. On `rvalid`:
  - `data_data_ok`=1, `data_rdata`=`rdata` (combinational pass-through).
  - Go to IDLE.
- WREQ:
  - `awvalid` stays high until its own handshake; flag `aw_done` set on `awvalid&awready`.
  - `wvalid` stays high until its own handshake; flag `w_done` set on `wvalid&wready`.
  - Handshakes may occur in either order or in the same cycle.
  - Go to WRESP once both are done; both flags clear on exit.
- WRESP: `bready`=1. On `bvalid`, `data_data_ok`=1 and go to IDLE.
- `arsize`/`awsize` = {1'b0, latched size}. The address is passed unmodified.
- `wstrb`:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: addr[1] ? 4'b1100 : 4'b0011.
  - size 2: 4'b1111.
  - size 3: 4'b1111 (treated as word).
- `wdata` = latched wdata, unshifted; the core already places lanes.
- `rresp`/`bresp` errors are ignored; completion is still signalled. `rid`/`bid` are not checked.

## Timing
- Reset (`resetn`=0 at an edge):
  - State becomes IDLE and the latches and done flags clear.
  - All valids, `rready`, `bready` and `data_data_ok` are 0.
  - `data_addr_ok` follows `data_req` combinationally.
  - Any in-flight AXI transaction is abandoned; the system reset covers the slave.
- Zero-wait read, `arready`=1:
  - Cycle 0: `addr_ok`.
  - Cycle 1: `arvalid`.
  - Cycle 2: `rvalid`, `data_ok`.
  - Total latency is 2 cycles.
- Zero-wait write: `addr_ok` at cycle 0, AW+W at cycle 1, B earliest at cycle 2, `data_ok` at that cycle.
- `data_addr_ok` is 0 outside IDLE, so `data_req` is held off while busy.
- After `data_ok` the next request is accepted the following cycle. Requests are never accepted in the same cycle as `data_ok`.
- Valids are held until their handshake, and their payloads stay stable (AXI rule).
- Only one transaction is ever outstanding.

## Structure
- Shared package `axi_pkg` holds:
  - Burst constant INCR = 2'b01.
  - Size encodings.
  - Response codes.
  - FSM state typedef `bridge_state_t`.
  - Data-side ID constant.
- Sub-module `sram_wstrb_gen` (combinational size+addr → wstrb), reused by the instruction side.

## Test plan
- Read, `arready`=1, `rvalid` one cycle later with `rdata`=0xDEADBEEF to addr 0x1FC00004 → `araddr`=0x1FC00004, `arsize`=2, `data_ok` at cycle 2 with `rdata`=0xDEADBEEF.
- Byte write addr 0x00000103 data 0x11000000 → `wstrb`=4'b1000, `awsize`=0, `wlast`=1, `data_ok` exactly one cycle on `bvalid`.
- Write with `wready` 3 cycles before `awready` → each valid drops only after its own handshake, a single WRESP, one `data_ok`.
- `data_req` held high while RDATA stalls 5 cycles → `addr_ok` stays 0 until the cycle after `data_ok`; the second request is then issued correctly.
- `resetn` low during WREQ → next cycle IDLE, `awvalid`=`wvalid`=0, no `data_ok`; a following read completes normally.
- Halfword write addr 0x2, `bresp`=SLVERR → `wstrb`=4'b1100, `data_ok` still asserted once.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants and bridge FSM encoding for the SRAM-to-AXI bridges.
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [2:0] bridge_state_t;
  localparam bridge_state_t ST_IDLE  = 3'd0;
  localparam bridge_state_t ST_RADDR = 3'd1;
  localparam bridge_state_t ST_RDATA = 3'd2;
  localparam bridge_state_t ST_WREQ  = 3'd3;
  localparam bridge_state_t ST_WRESP = 3'd4;

  localparam int DATA_AXI_ID = 1;

endpackage

// File: rtl/sram_wstrb_gen.sv
// Byte-lane strobe from SRAM-style size and low address bits.
module sram_wstrb_gen
  import axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   wstrb = 4'b1111;  // word, and size 3 treated as word
    endcase
  end

endmodule

// File: rtl/d_sram_axi_bridge.sv
// Data-cache SRAM-like port to single-beat AXI3 master, one transaction at a time.
module d_sram_axi_bridge
  import axi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int AXI_ID = DATA_AXI_ID
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic [31:0]     data_rdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready,
  output bridge_state_t   dbg_state
);

  // Handshake rule on every channel: a transfer happens on a rising edge where
  // valid & ready are both high; a raised valid and its payload stay unchanged
  // until that edge, and ready never depends on anything but the current state.

  bridge_state_t state;
  logic          lat_wr;
  logic [1:0]    lat_size;
  logic [31:0]   lat_addr;
  logic [31:0]   lat_wdata;
  logic          aw_done;
  logic          w_done;
  logic          aw_fin;
  logic          w_fin;

  // Responses and IDs are deliberately ignored: errors still complete the request.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

  assign aw_fin = aw_done | awready;
  assign w_fin  = w_done  | wready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (data_req) begin
            lat_wr    <= data_wr;
            lat_size  <= data_size;
            lat_addr  <= data_addr;
            lat_wdata <= data_wdata;
            state     <= data_wr ? ST_WREQ : ST_RADDR;
          end
        end
        ST_RADDR: if (arready) state <= ST_RDATA;
        ST_RDATA: if (rvalid) state <= ST_IDLE;
        ST_WREQ: begin
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= ST_WRESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        ST_WRESP: if (bvalid) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state    = state;
  assign data_addr_ok = (state == ST_IDLE) && data_req;
  assign data_data_ok = ((state == ST_RDATA) && rvalid) || ((state == ST_WRESP) && bvalid);
  assign data_rdata   = rdata;

  assign arid    = ID_W'(AXI_ID);
  assign araddr  = lat_addr;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, lat_size};
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == ST_RADDR);
  assign rready  = (state == ST_RDATA);

  assign awid    = ID_W'(AXI_ID);
  assign awaddr  = lat_addr;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, lat_size};
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state == ST_WREQ) && !aw_done;

  assign wid    = ID_W'(AXI_ID);
  assign wdata  = lat_wdata;
  assign wlast  = 1'b1;
  assign wvalid = (state == ST_WREQ) && !w_done && lat_wr;
  assign bready = (state == ST_WRESP);

  sram_wstrb_gen u_wstrb (
    .size    (lat_size),
    .addr_lo (lat_addr[1:0]),
    .wstrb   (wstrb)
  );

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Directed bench for d_sram_axi_bridge: one task per scenario, inline checks.
module tb_d_sram_axi_bridge;
  import axi_pkg::*;

  localparam int ID_W = 4;

  logic            clk;
  logic            resetn;
  logic            data_req;
  logic            data_wr;
  logic [1:0]      data_size;
  logic [31:0]     data_addr;
  logic [31:0]     data_wdata;
  logic [31:0]     data_rdata;
  logic            data_addr_ok;
  logic            data_data_ok;
  logic [ID_W-1:0] arid, awid, wid, rid, bid;
  logic [31:0]     araddr, awaddr, wdata, rdata;
  logic [3:0]      arlen, awlen, arcache, awcache, wstrb;
  logic [2:0]      arsize, awsize, arprot, awprot;
  logic [1:0]      arburst, awburst, arlock, awlock, rresp, bresp;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready;
  logic            bvalid, bready;
  bridge_state_t   dbg_state;

  int total = 0;
  int bad   = 0;
  int pulses;

  d_sram_axi_bridge #(.ID_W(ID_W), .AXI_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so inputs and outputs are away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                     input logic [31:0] wd);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wd;
    #1;
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++; $display("FAIL req_addr_ok: got %b want 1", data_addr_ok);
    end
    step();
    data_req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; data_req = 1'b1;
    step(); step();
    total++;
    if (dbg_state !== ST_IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE);
    end
    total++;
    if ({arvalid, awvalid, wvalid, rready, bready, data_data_ok} !== 6'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 000000",
                      {arvalid, awvalid, wvalid, rready, bready, data_data_ok});
    end
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++; $display("FAIL reset_addr_ok_hi: got %b want 1", data_addr_ok);
    end
    data_req = 1'b0; #1;
    total++;
    if (data_addr_ok !== 1'b0) begin
      bad++; $display("FAIL reset_addr_ok_lo: got %b want 0", data_addr_ok);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_read();
    req(1'b0, 2'd2, 32'h1FC0_0004, 32'h0);
    total++;
    if ({arvalid, araddr, arsize, arlen, arburst, arid} !== {1'b1, 32'h1FC0_0004, 3'd2, 4'd0, 2'b01, 4'd1}) begin
      bad++; $display("FAIL read_ar: got v=%b a=%h s=%0d l=%0d b=%b id=%0d want v=1 a=1fc00004 s=2 l=0 b=01 id=1",
                      arvalid, araddr, arsize, arlen, arburst, arid);
    end
    total++;
    if (data_data_ok !== 1'b0) begin
      bad++; $display("FAIL read_early_ok: got %b want 0", data_data_ok);
    end
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rlast = 1'b1; #1;
    total++;
    if ({rready, data_data_ok, data_rdata} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL read_data: got rr=%b ok=%b d=%h want rr=1 ok=1 d=deadbeef",
                      rready, data_data_ok, data_rdata);
    end
    step();
    rvalid = 1'b0; rlast = 1'b0; #1;
    total++;
    if ({data_data_ok, arvalid, rready, dbg_state} !== {3'b000, ST_IDLE}) begin
      bad++; $display("FAIL read_done: got ok=%b arv=%b rr=%b st=%0d want 0 0 0 0",
                      data_data_ok, arvalid, rready, dbg_state);
    end
  endtask

  task automatic test_byte_write();
    req(1'b1, 2'd0, 32'h0000_0103, 32'h1100_0000);
    total++;
    if ({awvalid, wvalid, awaddr, awsize, wstrb, wlast, wdata, awid, wid} !==
        {2'b11, 32'h0000_0103, 3'd0, 4'b1000, 1'b1, 32'h1100_0000, 4'd1, 4'd1}) begin
      bad++; $display("FAIL bwr_req: got av=%b wv=%b a=%h s=%0d st=%b l=%b d=%h want 1 1 00000103 0 1000 1 11000000",
                      awvalid, wvalid, awaddr, awsize, wstrb, wlast, wdata);
    end
    awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0; #1;
    total++;
    if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin
      bad++; $display("FAIL bwr_wresp: got av=%b wv=%b br=%b ok=%b want 0 0 1 0",
                      awvalid, wvalid, bready, data_data_ok);
    end
    bvalid = 1'b1; bresp = RESP_OKAY; #1;
    total++;
    if (data_data_ok !== 1'b1) begin
      bad++; $display("FAIL bwr_ok: got %b want 1", data_data_ok);
    end
    step();
    bvalid = 1'b0; #1;
    total++;
    if ({data_data_ok, bready} !== 2'b00) begin
      bad++; $display("FAIL bwr_ok_once: got ok=%b br=%b want 0 0", data_data_ok, bready);
    end
  endtask

  task automatic test_w_before_aw();
    req(1'b1, 2'd2, 32'h0000_0040, 32'hA5A5_5A5A);
    wready = 1'b1;
    step();
    wready = 1'b0; #1;
    total++;
    if ({awvalid, wvalid, dbg_state} !== {2'b10, ST_WREQ}) begin
      bad++; $display("FAIL ooo_w_first: got av=%b wv=%b st=%0d want 1 0 3", awvalid, wvalid, dbg_state);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({awvalid, wvalid, awaddr, wstrb} !== {2'b10, 32'h0000_0040, 4'b1111}) begin
        bad++; $display("FAIL ooo_hold%0d: got av=%b wv=%b a=%h st=%b want 1 0 00000040 1111",
                        i, awvalid, wvalid, awaddr, wstrb);
      end
    end
    awready = 1'b1;
    step();
    awready = 1'b0; #1;
    total++;
    if ({awvalid, wvalid, dbg_state} !== {2'b00, ST_WRESP}) begin
      bad++; $display("FAIL ooo_wresp: got av=%b wv=%b st=%0d want 0 0 4", awvalid, wvalid, dbg_state);
    end
    pulses = 0;
    bvalid = 1'b1; #1;
    if (data_data_ok === 1'b1) pulses++;
    step(); bvalid = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      if (data_data_ok === 1'b1) pulses++;
      step();
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL ooo_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_0400; #1;
    total++;
    if (data_addr_ok !== 1'b1) begin
      bad++; $display("FAIL b2b_first_ok: got %b want 1", data_addr_ok);
    end
    step();
    arready = 1'b1; #1;
    total++;
    if (data_addr_ok !== 1'b0) begin
      bad++; $display("FAIL b2b_raddr_busy: got %b want 0", data_addr_ok);
    end
    step();
    arready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({data_addr_ok, data_data_ok, rready} !== 3'b001) begin
        bad++; $display("FAIL b2b_stall%0d: got aok=%b ok=%b rr=%b want 0 0 1",
                        i, data_addr_ok, data_data_ok, rready);
      end
      step();
    end
    rvalid = 1'b1; rdata = 32'h1234_5678;
    data_addr = 32'h0000_0080; #1;
    total++;
    if ({data_addr_ok, data_data_ok, data_rdata} !== {2'b01, 32'h1234_5678}) begin
      bad++; $display("FAIL b2b_ok_cycle: got aok=%b ok=%b d=%h want 0 1 12345678",
                      data_addr_ok, data_data_ok, data_rdata);
    end
    step();
    rvalid = 1'b0; #1;
    total++;
    if ({data_addr_ok, data_data_ok} !== 2'b10) begin
      bad++; $display("FAIL b2b_second_accept: got aok=%b ok=%b want 1 0", data_addr_ok, data_data_ok);
    end
    step();
    data_req = 1'b0; #1;
    total++;
    if ({arvalid, araddr} !== {1'b1, 32'h0000_0080}) begin
      bad++; $display("FAIL b2b_second_ar: got v=%b a=%h want 1 00000080", arvalid, araddr);
    end
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h0BAD_F00D; #1;
    total++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
      bad++; $display("FAIL b2b_second_data: got ok=%b d=%h want 1 0badf00d", data_data_ok, data_rdata);
    end
    step(); rvalid = 1'b0; #1;
  endtask

  task automatic test_reset_in_wreq();
    req(1'b1, 2'd2, 32'h0000_0010, 32'h7777_7777);
    total++;
    if (dbg_state !== ST_WREQ) begin
      bad++; $display("FAIL rst_wreq_entry: got %0d want 3", dbg_state);
    end
    resetn = 1'b0;
    step();
    total++;
    if ({dbg_state, awvalid, wvalid, data_data_ok} !== {ST_IDLE, 3'b000}) begin
      bad++; $display("FAIL rst_wreq_abandon: got st=%0d av=%b wv=%b ok=%b want 0 0 0 0",
                      dbg_state, awvalid, wvalid, data_data_ok);
    end
    resetn = 1'b1;
    step();
    req(1'b0, 2'd2, 32'h0000_0008, 32'h0);
    arready = 1'b1; step(); arready = 1'b0;
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; #1;
    total++;
    if ({data_data_ok, data_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      bad++; $display("FAIL rst_follow_read: got ok=%b d=%h want 1 cafef00d", data_data_ok, data_rdata);
    end
    step(); rvalid = 1'b0; #1;
  endtask

  task automatic test_half_slverr();
    req(1'b1, 2'd1, 32'h0000_0002, 32'hBEEF_0000);
    total++;
    if ({wstrb, awsize} !== {4'b1100, 3'd1}) begin
      bad++; $display("FAIL half_strb: got st=%b s=%0d want 1100 1", wstrb, awsize);
    end
    awready = 1'b1; wready = 1'b1; step(); awready = 1'b0; wready = 1'b0;
    pulses = 0;
    bvalid = 1'b1; bresp = RESP_SLVERR; #1;
    if (data_data_ok === 1'b1) pulses++;
    step(); bvalid = 1'b0; bresp = RESP_OKAY; #1;
    for (int i = 0; i < 2; i++) begin
      if (data_data_ok === 1'b1) pulses++;
      step();
    end
    total++;
    if (pulses !== 1) begin
      bad++; $display("FAIL half_slverr_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_strobes();
    logic [1:0] sz [4];
    logic [1:0] lo [4];
    logic [3:0] ex [4];
    sz = '{2'd0, 2'd1, 2'd3, 2'd0};
    lo = '{2'd0, 2'd0, 2'd1, 2'd2};
    ex = '{4'b0001, 4'b0011, 4'b1111, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      req(1'b1, sz[i], {30'h0000_0100, lo[i]}, 32'h0);
      total++;
      if ({wstrb, awsize} !== {ex[i], 1'b0, sz[i]}) begin
        bad++; $display("FAIL strobe%0d: got st=%b s=%0d want %b %0d", i, wstrb, awsize, ex[i], sz[i]);
      end
      awready = 1'b1; wready = 1'b1; step(); awready = 1'b0; wready = 1'b0;
      bvalid = 1'b1; step(); bvalid = 1'b0; #1;
    end
  endtask

  initial begin
    resetn = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'h0; data_wdata = 32'h0;
    arready = 1'b0; rid = 4'd1; rdata = 32'h0; rresp = RESP_OKAY; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = RESP_OKAY; bvalid = 1'b0;
    test_reset();
    test_read();
    test_byte_write();
    test_w_before_aw();
    test_back_to_back();
    test_reset_in_wreq();
    test_half_slverr();
    test_strobes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
